// File: rtl/archie_pkg.sv
// archie_pkg: loader state encoding and Wishbone byte-lane selection shared by the loader files.
package archie_pkg;
    typedef enum logic [1:0] {S_IDLE, S_ERASE, S_LOAD, S_FLUSH} ld_state_e;
    // wide: 16-bit halves on addr[1]; otherwise one byte lane on addr[1:0]
    function automatic logic [3:0] sel_lane(input logic [1:0] a, input logic wide);
        return wide ? (a[1] ? 4'b1100 : 4'b0011) : 4'b0001 << a;
    endfunction
endpackage

// File: rtl/rom_loader_if.sv
// rom_loader_if: HPS ioctl download port and Wishbone write bus used by the ROM loader.
interface ioctl_if #(parameter int AW = 22, parameter int IOW = 16);
    logic           ioctl_download;
    logic [7:0]     ioctl_index;
    logic           ioctl_wr;
    logic [AW+1:0]  ioctl_addr;
    logic [IOW-1:0] ioctl_dout;
    logic           ioctl_wait;
    modport master (output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, input ioctl_wait);
    modport slave (input ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, output ioctl_wait);
endinterface

interface wb_if #(parameter int AW = 22);
    logic          wb_cyc;
    logic          wb_stb;
    logic          wb_we;
    logic [3:0]    wb_sel;
    logic [AW-1:0] wb_adr;
    logic [31:0]   wb_dat_o;
    logic          wb_ack;
    modport master (output wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_o, input wb_ack);
    modport slave (input wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_o, output wb_ack);
endinterface

// File: rtl/rom_loader_timeout.sv
// loader_timeout: loadable down-counter that flags expiry while enabled.
module loader_timeout #(
    parameter int W = 10
) (
    input  logic         clk_sys,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    input  logic         en_i,
    output logic         expire_o
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = load_i ? val_i : (en_i && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
    always_ff @(posedge clk_sys) cnt_q <= reset ? '0 : cnt_d;
    assign expire_o = en_i && cnt_q == '0;
endmodule

// File: rtl/rom_loader.sv
// rom_loader: optionally clears a memory region, then writes an HPS ioctl download into it over Wishbone.
module rom_loader
    import archie_pkg::*;
#(
    parameter int          IDX         = 8,
    parameter int          IOW         = 16,
    parameter int          AW          = 22,
    parameter int          BASE        = 'h100000,
    parameter int          ERASE_WORDS = 'h100000,
    parameter logic [31:0] FILL        = '0,
    parameter int          TMO         = 1023
) (
    input  logic   clk_sys,
    input  logic   reset,
    ioctl_if.slave io,
    wb_if.master   wb,
    output logic   active,
    output logic   done,
    output logic   err
);
    localparam int TW = $clog2(TMO + 1);
    ld_state_e     state_q, state_d;
    logic          pend_q, pend_d, err_q, err_d, done_q, done_d, trunc_q, trunc_d, dl_q;
    logic [AW-1:0] adr_q, adr_d;
    logic [31:0]   dat_q, dat_d, cnt_q, cnt_d;
    logic [3:0]    sel_q, sel_d;
    logic          dl_match, start, acc, last, tmo_load, tmo_exp;

    assign dl_match = io.ioctl_download && io.ioctl_index == 8'(IDX);
    assign start    = dl_match && !dl_q;
    assign acc      = io.ioctl_wr && !pend_q;
    assign last     = cnt_q == 32'(ERASE_WORDS - 1);
    assign tmo_load = pend_d && (!pend_q || wb.wb_ack);

    loader_timeout #(.W(TW)) u_tmo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .load_i  (tmo_load),
        .val_i   (TW'(TMO - 1)),
        .en_i    (pend_q),
        .expire_o(tmo_exp)
    );

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q && !wb.wb_ack;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        err_d   = err_q || (io.ioctl_wr && pend_q);
        trunc_d = trunc_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = ERASE_WORDS > 0 ? S_ERASE : S_LOAD;
                pend_d  = ERASE_WORDS > 0;
                adr_d   = AW'(BASE);
                dat_d   = FILL;
                sel_d   = 4'b1111;
                cnt_d   = '0;
                err_d   = 1'b0;
                trunc_d = 1'b0;
            end
            S_ERASE: begin
                if (wb.wb_ack && !last && dl_match) begin
                    pend_d = 1'b1;
                    adr_d  = adr_q + AW'(1);
                    cnt_d  = cnt_q + 32'd1;
                end
                if (wb.wb_ack && last) state_d = S_LOAD;
                // an erase is only complete if its final ack lands no later than the download fall
                if (!dl_match) begin
                    state_d = S_FLUSH;
                    trunc_d = !(wb.wb_ack && last);
                end
            end
            S_LOAD: begin
                if (acc) begin
                    pend_d = 1'b1;
                    adr_d  = AW'(BASE) + io.ioctl_addr[AW+1:2];
                    dat_d  = {(32 / IOW){io.ioctl_dout}};
                    sel_d  = sel_lane(io.ioctl_addr[1:0], IOW == 16);
                end
                if (!dl_match) state_d = S_FLUSH;
            end
            S_FLUSH: if (!pend_d) begin
                state_d = S_IDLE;
                done_d  = !trunc_q && !err_d;
            end
        endcase
        if (pend_q && !wb.wb_ack && tmo_exp) begin
            pend_d  = 1'b0;
            err_d   = 1'b1;
            state_d = S_IDLE;
            done_d  = 1'b0;
        end
    end

    // tracking the download level through reset blocks a restart until it falls and rises again
    always_ff @(posedge clk_sys) begin
        dl_q <= dl_match;
        if (reset) begin
            state_q <= S_IDLE;
            pend_q  <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            done_q  <= done_d;
            trunc_q <= trunc_d;
        end
    end

    assign wb.wb_cyc    = pend_q;
    assign wb.wb_stb    = pend_q;
    assign wb.wb_we     = pend_q;
    assign wb.wb_sel    = sel_q;
    assign wb.wb_adr    = adr_q;
    assign wb.wb_dat_o  = dat_q;
    assign io.ioctl_wait = pend_q;
    assign active       = state_q != S_IDLE;
    assign done         = done_q;
    assign err          = err_q;
endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: randomized download sessions on a 16-bit erasing loader and an 8-bit non-erasing loader,
// checked against an expected bus-write list built from the address/lane/replication rules.
module tb_rom_loader;
    localparam int          AW   = 22;
    localparam int          IDX  = 8;
    localparam int          BASE = 'h3FFFF0;
    localparam int          NE   = 4;
    localparam int          TMO  = 15;
    localparam logic [31:0] FILL = 32'hDEADBEEF;

    typedef struct packed {logic [AW-1:0] adr; logic [31:0] dat; logic [3:0] sel;} wr_t;

    logic clk_sys = 1'b0, reset = 1'b1, ack_en = 1'b1, gap_en = 1'b0;
    logic act16, act8, done16, done8, err16, err8;
    int   n_cmp = 0, n_bad = 0, done16_n = 0, done8_n = 0, stb16_n = 0, stb8_n = 0, gap = 0, proto = 0;
    wr_t  rx16[$], rx8[$], ex16[$], ex8[$];

    ioctl_if #(.AW(AW), .IOW(16)) i16();
    ioctl_if #(.AW(AW), .IOW(8))  i8();
    wb_if #(.AW(AW)) w16();
    wb_if #(.AW(AW)) w8();

    assign i8.ioctl_download = i16.ioctl_download;
    assign i8.ioctl_index    = i16.ioctl_index;
    assign i8.ioctl_wr       = i16.ioctl_wr;
    assign i8.ioctl_addr     = i16.ioctl_addr;
    assign i8.ioctl_dout     = i16.ioctl_dout[7:0];

    rom_loader #(.IDX(IDX), .IOW(16), .AW(AW), .BASE(BASE), .ERASE_WORDS(NE), .FILL(FILL), .TMO(TMO)) dut16 (
        .clk_sys(clk_sys), .reset(reset), .io(i16), .wb(w16), .active(act16), .done(done16), .err(err16));
    rom_loader #(.IDX(IDX), .IOW(8), .AW(AW), .BASE(BASE), .ERASE_WORDS(0), .FILL(FILL), .TMO(TMO)) dut8 (
        .clk_sys(clk_sys), .reset(reset), .io(i8), .wb(w8), .active(act8), .done(done8), .err(err8));

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        w16.wb_ack <= !reset && ack_en && w16.wb_stb && !w16.wb_ack;
        w8.wb_ack  <= !reset && ack_en && w8.wb_stb && !w8.wb_ack;
    end

    always @(negedge clk_sys) begin
        if (gap_en && act16 && !i16.ioctl_wait && rx16.size() < NE) gap++;
        if ((w16.wb_cyc && !w16.wb_we) || (!act16 && w16.wb_cyc) || (w8.wb_cyc && !w8.wb_we) || (!act8 && w8.wb_cyc)) proto++;
        if (w16.wb_stb && w16.wb_ack) rx16.push_back({w16.wb_adr, w16.wb_dat_o, w16.wb_sel});
        if (w8.wb_stb && w8.wb_ack) rx8.push_back({w8.wb_adr, w8.wb_dat_o, w8.wb_sel});
        if (w16.wb_stb) stb16_n++;
        if (w8.wb_stb) stb8_n++;
        if (done16) done16_n++;
        if (done8) done8_n++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic wr_t exp_wr(input int iow, input logic [23:0] a, input logic [15:0] d);
        wr_t w;
        w.adr = AW'((BASE + int'(a >> 2)) % (1 << AW));
        w.dat = (iow == 16) ? {16'h0, d} * 32'h0001_0001 : {24'h0, d[7:0]} * 32'h0101_0101;
        w.sel = (iow == 16) ? (a[1] ? 4'b1100 : 4'b0011) : 4'(1 << a[1:0]);
        return w;
    endfunction

    task automatic clr();
        rx16.delete(); rx8.delete(); ex16.delete(); ex8.delete();
        done16_n = 0; done8_n = 0; stb16_n = 0; stb8_n = 0; gap = 0;
    endtask

    task automatic push_erase();
        for (int k = 0; k < NE; k++) ex16.push_back({AW'(BASE + k), FILL, 4'b1111});
    endtask

    task automatic start_dl(input logic [7:0] idx);
        @(negedge clk_sys);
        i16.ioctl_index = idx;
        i16.ioctl_download = 1'b1;
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((i16.ioctl_wait || i8.ioctl_wait) && n < 100) begin
            @(negedge clk_sys);
            n++;
        end
        check("wait_release", {i16.ioctl_wait, i8.ioctl_wait}, 0);
    endtask

    task automatic drive_wr(input logic [23:0] a, input logic [15:0] d, input logic fall, input logic e16, input logic e8);
        @(negedge clk_sys);
        i16.ioctl_addr = a;
        i16.ioctl_dout = d;
        i16.ioctl_wr = 1'b1;
        if (fall) i16.ioctl_download = 1'b0;
        if (e16) ex16.push_back(exp_wr(16, a, d));
        if (e8) ex8.push_back(exp_wr(8, a, d));
        @(negedge clk_sys);
        i16.ioctl_wr = 1'b0;
    endtask

    task automatic cmp_q(input string tag);
        check({tag, "_n16"}, rx16.size(), ex16.size());
        check({tag, "_n8"}, rx8.size(), ex8.size());
        for (int i = 0; i < ex16.size() && i < rx16.size(); i++) check({tag, "_wr16"}, rx16[i], ex16[i]);
        for (int i = 0; i < ex8.size() && i < rx8.size(); i++) check({tag, "_wr8"}, rx8[i], ex8[i]);
    endtask

    initial begin
        logic [23:0] a;
        logic [15:0] d;
        i16.ioctl_download = 1'b0;
        i16.ioctl_index = '0;
        i16.ioctl_wr = 1'b0;
        i16.ioctl_addr = '0;
        i16.ioctl_dout = '0;
        repeat (3) @(negedge clk_sys);
        check("rst16", {act16, done16, err16, w16.wb_cyc, w16.wb_stb, w16.wb_we, w16.wb_sel, i16.ioctl_wait}, 0);
        check("rst16_bus", {w16.wb_adr, w16.wb_dat_o}, 0);
        check("rst8", {act8, done8, err8, w8.wb_cyc, w8.wb_sel, i8.ioctl_wait}, 0);
        reset = 1'b0;
        // normal session: erase, directed lane cases, random writes
        clr(); gap_en = 1'b1;
        start_dl(IDX); push_erase();
        wait_idle(); drive_wr(24'd0, 16'h1234, 1'b0, 1'b1, 1'b1);
        wait_idle(); drive_wr(24'd2, 16'hABCD, 1'b0, 1'b1, 1'b1);
        wait_idle(); drive_wr(24'd3, 16'h005A, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 6; k++) begin
            wait_idle();
            drive_wr(24'($urandom_range(0, 255)), 16'($urandom), 1'b0, 1'b1, 1'b1);
        end
        wait_idle();
        @(negedge clk_sys) i16.ioctl_download = 1'b0;
        repeat (8) @(negedge clk_sys);
        cmp_q("A");
        check("A_done", {8'(done16_n), 8'(done8_n)}, {8'd1, 8'd1});
        check("A_err", {err16, err8}, 0);
        check("A_gap", gap, 0);
        check("A_idle", {act16, act8}, 0);
        gap_en = 1'b0;
        // withheld acks: erase cycle on dut16, load cycle on dut8 both time out
        clr(); ack_en = 1'b0;
        start_dl(IDX);
        repeat (25) @(negedge clk_sys);
        check("B_len16", stb16_n, TMO);
        check("B_err16", err16, 1);
        check("B_idle16", act16, 0);
        wait_idle(); drive_wr(24'd8, 16'h7777, 1'b0, 1'b0, 1'b0);
        repeat (25) @(negedge clk_sys);
        check("B_len8", stb8_n, TMO);
        check("B_err8", err8, 1);
        check("B_idle8", act8, 0);
        @(negedge clk_sys) i16.ioctl_download = 1'b0;
        repeat (5) @(negedge clk_sys);
        check("B_done", {8'(done16_n), 8'(done8_n)}, 0);
        cmp_q("B");
        ack_en = 1'b1;
        // write strobe while ioctl_wait is high is dropped and flags err
        clr();
        start_dl(IDX); push_erase();
        wait_idle();
        a = 24'($urandom_range(0, 255)); d = 16'($urandom);
        @(negedge clk_sys);
        i16.ioctl_addr = a; i16.ioctl_dout = d; i16.ioctl_wr = 1'b1;
        ex16.push_back(exp_wr(16, a, d)); ex8.push_back(exp_wr(8, a, d));
        @(negedge clk_sys);
        i16.ioctl_addr = a ^ 24'd4; i16.ioctl_dout = ~d;
        check("C_wait", {i16.ioctl_wait, i8.ioctl_wait}, 2'b11);
        @(negedge clk_sys) i16.ioctl_wr = 1'b0;
        wait_idle();
        @(negedge clk_sys) i16.ioctl_download = 1'b0;
        repeat (8) @(negedge clk_sys);
        cmp_q("C");
        check("C_err", {err16, err8}, 2'b11);
        check("C_done", {8'(done16_n), 8'(done8_n)}, 0);
        // reset in the middle of an erase, with the download left high
        start_dl(IDX);
        @(negedge clk_sys) reset = 1'b1;
        @(negedge clk_sys);
        check("D_rst16", {act16, done16, err16, w16.wb_cyc, w16.wb_stb, w16.wb_we, w16.wb_sel, i16.ioctl_wait}, 0);
        check("D_rst16_bus", {w16.wb_adr, w16.wb_dat_o}, 0);
        check("D_rst8", {act8, done8, err8, w8.wb_cyc, i8.ioctl_wait}, 0);
        reset = 1'b0;
        clr();
        repeat (20) @(negedge clk_sys);
        check("D_hold", {act16, act8}, 0);
        check("D_nowr", rx16.size() + rx8.size(), 0);
        @(negedge clk_sys) i16.ioctl_download = 1'b0;
        clr();
        start_dl(IDX);
        check("D_restart", {act16, act8}, 2'b11);
        @(negedge clk_sys) i16.ioctl_download = 1'b0;
        repeat (10) @(negedge clk_sys);
        check("D_trunc16", done16_n, 0);
        check("D_done8", done8_n, 1);
        check("D_idle", {act16, act8}, 0);
        // last write lands in the same cycle the download falls
        clr(); gap_en = 1'b1;
        start_dl(IDX); push_erase();
        for (int k = 0; k < 8; k++) begin
            wait_idle();
            drive_wr(24'($urandom_range(0, 255)), 16'($urandom), k == 7, 1'b1, 1'b1);
        end
        repeat (10) @(negedge clk_sys);
        cmp_q("E");
        check("E_done", {8'(done16_n), 8'(done8_n)}, {8'd1, 8'd1});
        check("E_err", {err16, err8}, 0);
        check("E_gap", gap, 0);
        check("E_idle", {act16, act8}, 0);
        gap_en = 1'b0;
        // foreign index is ignored
        clr();
        start_dl(8'(IDX + 1));
        repeat (5) @(negedge clk_sys);
        check("F_idx", {act16, act8, w16.wb_cyc, w8.wb_cyc}, 0);
        @(negedge clk_sys) i16.ioctl_download = 1'b0;
        check("protocol", proto, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 Parameters: IDX 8, ioctl index accepted; IOW 16, ioctl data width (8 or 16); AW 22, word-address width; BASE 'h100000, word base address of image; ERASE_WORDS 'h100000, words cleared before load (0 = no erase); FILL 0, 32-bit erase pattern; TMO 1023, ack timeout in cycles.
REQ-002 clk_sys  in  1  system clock; all logic on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 ioctl_download  in  1  HPS download active.
REQ-005 ioctl_index  in  8  download target index.
REQ-006 ioctl_wr  in  1  one-cycle data strobe.
REQ-007 ioctl_addr  in  AW+2  byte address within image.
REQ-008 ioctl_dout  in  IOW  download data.
REQ-009 ioctl_wait  out  1  stalls HPS.
REQ-010 wb_cyc, wb_stb, wb_we  out  1 each  Wishbone master controls.
REQ-011 wb_sel  out  4  byte lanes; wb_adr  out  AW  word address; wb_dat_o  out  32  write data.
REQ-012 wb_ack  in  1  slave acknowledge.
REQ-013 active  out  1  high while download matches IDX (selects loader as bus owner).
REQ-014 done  out  1  one-cycle pulse on clean completion; err  out  1  sticky timeout/overrun flag.

Function
REQ-015 States: IDLE, ERASE, LOAD, FLUSH; active = (state != IDLE).
REQ-016 IDLE->ERASE on rising edge of (ioctl_download && ioctl_index==IDX) when ERASE_WORDS>0, else IDLE->LOAD; err cleared on that edge.
REQ-017 ERASE: back-to-back writes of FILL, wb_sel=4'b1111, addresses BASE..BASE+ERASE_WORDS-1; counter advances only on wb_ack; after last ack, ERASE->LOAD.
REQ-018 ioctl_wait SHALL be high throughout ERASE and from the cycle after an accepted ioctl_wr until the cycle after its wb_ack.
REQ-019 LOAD: ioctl_wr with ioctl_wait low captures data/address; wb_stb/wb_cyc/wb_we rise next cycle and hold until wb_ack; wb_adr = BASE + ioctl_addr[AW+1:2] (modulo 2^AW).
REQ-020 IOW=16: wb_sel = ioctl_addr[1] ? 4'b1100 : 4'b0011, wb_dat_o = data replicated twice; IOW=8: wb_sel one-hot on ioctl_addr[1:0], data replicated four times.
REQ-021 ioctl_wr while ioctl_wait high SHALL be dropped and set err.
REQ-022 No bus cycle outstanding longer than TMO cycles: on timeout, drop stb/cyc, set err, go IDLE, release ioctl_wait.
REQ-023 Download deassert during ERASE or LOAD: finish outstanding cycle (FLUSH) then IDLE; done pulses only if no erase was truncated and err is low.
REQ-024 ioctl_wr and download-fall in same cycle: the write is performed before FLUSH completes.
REQ-025 wb_stb/wb_cyc never asserted in IDLE; wb_we = 1 whenever wb_cyc is high.

Reset
REQ-026 reset forces state IDLE, wb_cyc/wb_stb/wb_we/done/err/ioctl_wait/active to 0, wb_sel/wb_adr/wb_dat_o to 0, counters to 0, within the same edge, including mid-cycle (outstanding ack ignored).
REQ-027 A download already active when reset releases SHALL NOT start a load until it falls and rises again.

Structure
REQ-028 State enum and the sel-lane function live in shared package archie_pkg.
REQ-029 One sub-module, loader_timeout (loadable down-counter with expire flag); everything else flat.

Verification
REQ-030 ERASE_WORDS=4, FILL='hDEADBEEF, ack 1-cycle -> 4 writes at BASE..BASE+3, sel 1111, ioctl_wait high throughout, then LOAD.
REQ-031 IOW=16, writes 'h1234 at addr 0 and 'hABCD at addr 2 -> wb_adr=BASE, sel 0011 data 'h12341234, then sel 1100 data 'hABCDABCD; done pulses once after download falls.
REQ-032 IOW=8, addr 3 data 'h5A -> sel 1000, data 'h5A5A5A5A.
REQ-033 wb_ack withheld, TMO=15 -> stb drops 15 cycles after assertion, err=1, state IDLE, done never pulses.
REQ-034 ioctl_wr injected while ioctl_wait=1 -> no bus cycle, err=1; reset asserted mid-ERASE -> all outputs 0 next edge, no restart until download re-rises.
